// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - address map shared by the MMIO responder and its users
package io_pkg;

    localparam logic [7:0] IO_LED      = 8'h00;
    localparam logic [7:0] IO_SEG_RDY  = 8'h04;
    localparam logic [7:0] IO_SEG_DATA = 8'h08;
    localparam logic [7:0] IO_SW_RDY   = 8'h0C;
    localparam logic [7:0] IO_SW_DATA  = 8'h10;
    localparam logic [7:0] IO_CYCLE    = 8'h14;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser and counter debounce for the capture button
module btn_debounce #(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          level_d;

    // Bring the asynchronous button into the clock domain before anything looks at it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; flip the stable level once the run is long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (sync2 != level_q) begin
            if (cnt == CW'(DB_CYCLES)) begin
                level_q <= ~level_q;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Delayed copy of the stable level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_d;

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - register bank behind the 8-bit MMIO bus
module mmio_responder
    import io_pkg::*;
#(
    parameter int DB_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [31:0] seg_data,
    output logic        seg_valid,
    input  logic        seg_ack
);

    logic [15:0] sw_sync1;
    logic [15:0] sw_sync2;
    logic [15:0] sw_data;
    logic        sw_ready;
    logic [31:0] cycle_cnt;
    logic        btn_level;
    logic        btn_rise;
    logic        capture;

    logic wr_led;
    logic wr_seg;
    logic wr_cycle;
    logic rd_sw_data;

    assign wr_led     = io_we && (io_addr == IO_LED);
    assign wr_seg     = io_we && (io_addr == IO_SEG_DATA);
    assign wr_cycle   = io_we && (io_addr == IO_CYCLE);
    assign rd_sw_data = io_rd && (io_addr == IO_SW_DATA);

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // A rise pulse is only meaningful while the stable level is high
    assign capture = btn_rise & btn_level;

    // Switches are asynchronous; synchronise them the same way as the button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
        end
    end

    // LED register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else if (wr_led) begin
            led <= io_dout[15:0];
        end
    end

    // Seven-segment value with pending flag; a write beats a same-cycle ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data  <= '0;
            seg_valid <= 1'b0;
        end else if (wr_seg) begin
            seg_data  <= io_dout;
            seg_valid <= 1'b1;
        end else if (seg_ack) begin
            seg_valid <= 1'b0;
        end
    end

    // Switch capture on a debounced press; a new capture beats a same-cycle read-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_data  <= '0;
            sw_ready <= 1'b0;
        end else if (capture) begin
            sw_data  <= sw_sync2;
            sw_ready <= 1'b1;
        end else if (rd_sw_data) begin
            sw_ready <= 1'b0;
        end
    end

    // Free-running cycle counter, cleared by any write to its address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (wr_cycle) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Zero-latency read mux on the full address; unmapped addresses read 0
    always_comb begin
        io_din = '0;
        case (io_addr)
            IO_LED:      io_din = {16'b0, led};
            IO_SEG_RDY:  io_din = {31'b0, ~seg_valid};
            IO_SEG_DATA: io_din = seg_data;
            IO_SW_RDY:   io_din = {31'b0, sw_ready};
            IO_SW_DATA:  io_din = {16'b0, sw_data};
            IO_CYCLE:    io_din = cycle_cnt;
            default:     io_din = '0;
        endcase
    end

endmodule
